// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding, default sizing and index-width helper for sort_sequencer.
package sort_pkg;
    typedef enum logic [1:0] {IDLE, SORT, SHOW} state_t;
    localparam int DEPTH_DEFAULT = 8;
    localparam int WIDTH_DEFAULT = 16;
    localparam int DWELL_DEFAULT = 100000000;
    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: free-running 0..DWELL_CYCLES-1 counter with enable and sync clear;
// o_tc pulses on the enabled terminal cycle.
module dwell_timer #(
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    logic [CW-1:0] r_cnt;
    assign o_tc = i_en && (r_cnt == CW'(DWELL_CYCLES - 1));
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
    end
endmodule

// File: rtl/sort_sequencer.sv
// sort_sequencer: loads up to DEPTH values, bubble-sorts them in place, then cycles them on outputVal.
// Define SORT_DESCENDING_EN to sort and present largest first.
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int WIDTH        = WIDTH_DEFAULT,
    parameter int DWELL_CYCLES = DWELL_DEFAULT
) (
    input  logic                        CLK100MHZ,
    input  logic                        CPU_RESETN,
    input  logic                        load_valid,
    input  logic [WIDTH-1:0]            load_data,
    output logic                        load_ready,
    input  logic                        start,
    input  logic                        clear,
    output logic                        busy,
    output logic                        done,
    output logic [idx_width(DEPTH)-1:0] out_index,
    output logic [WIDTH-1:0]            outputVal
);
    localparam int IW = idx_width(DEPTH);
    localparam int CW = IW + 1;

    state_t          r_state, w_next;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]   r_count, w_cnt_post;
    logic [IW-1:0]   r_i, r_limit, r_rd, r_oidx, w_limit0;
    logic            r_swapped;
    logic [WIDTH-1:0] r_out, w_a, w_b;
    logic            w_xfer, w_swap, w_last, w_sort_exit, w_tc, w_enter_show, w_rd_wrap;

    assign load_ready = (r_state == IDLE) && (r_count < CW'(DEPTH));
    assign busy       = (r_state == SORT);
    assign done       = (r_state == SHOW);
    assign outputVal  = r_out;
    assign out_index  = r_oidx;

    assign w_xfer     = load_valid && load_ready && !clear;
    assign w_cnt_post = r_count + CW'(w_xfer);
    assign w_a        = r_mem[r_i];
    assign w_b        = r_mem[r_i + IW'(1)];
`ifdef SORT_DESCENDING_EN
    assign w_swap     = (r_state == SORT) && (w_a < w_b);
`else
    assign w_swap     = (r_state == SORT) && (w_a > w_b);
`endif
    assign w_last      = (r_i == r_limit - IW'(1));
    assign w_sort_exit = w_last && (!(r_swapped || w_swap) || r_limit == IW'(1));
    assign w_limit0    = IW'(((r_state == IDLE) ? w_cnt_post : r_count) - CW'(1));
    assign w_enter_show = (w_next == SHOW) && (r_state != SHOW);
    assign w_rd_wrap    = ({1'b0, r_rd} == r_count - CW'(1));

    always_comb begin
        w_next = r_state;
        if (clear)
            w_next = IDLE;
        else if (r_state == IDLE && start)
            w_next = (w_cnt_post >= CW'(2)) ? SORT : (w_cnt_post == CW'(1)) ? SHOW : IDLE;
        else if (r_state == SORT && w_sort_exit)
            w_next = SHOW;
        else if (r_state == SHOW && start && r_count >= CW'(2))
            w_next = SORT;
    end

    // Storage is deliberately left unreset; only count decides which entries are live.
    always_ff @(posedge CLK100MHZ) begin
        if (w_xfer)
            r_mem[r_count[IW-1:0]] <= load_data;
        else if (w_swap && !clear) begin
            r_mem[r_i]          <= w_b;
            r_mem[r_i + IW'(1)] <= w_a;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_i       <= '0;
            r_limit   <= '0;
            r_swapped <= 1'b0;
            r_rd      <= '0;
            r_out     <= '0;
            r_oidx    <= '0;
        end else begin
            r_state <= w_next;
            if (clear)
                r_count <= '0;
            else if (w_xfer)
                r_count <= w_cnt_post;
            if (w_next == SORT && r_state != SORT) begin
                r_i       <= '0;
                r_limit   <= w_limit0;
                r_swapped <= 1'b0;
            end else if (r_state == SORT) begin
                r_i       <= w_last ? '0 : r_i + IW'(1);
                r_limit   <= w_last ? r_limit - IW'(1) : r_limit;
                r_swapped <= !w_last && (r_swapped || w_swap);
            end
            if (w_enter_show)
                r_rd <= '0;
            else if (r_state == SHOW && w_tc)
                r_rd <= w_rd_wrap ? '0 : r_rd + IW'(1);
            // Output register lags rd by one edge so each value sits exactly one dwell period.
            if (r_state == SHOW && !clear) begin
                r_out  <= r_mem[r_rd];
                r_oidx <= r_rd;
            end
        end
    end

    dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
        .i_clk   (CLK100MHZ),
        .i_rst_n (CPU_RESETN),
        .i_en    (r_state == SHOW),
        .i_clr   (w_enter_show),
        .o_tc    (w_tc)
    );
endmodule

// File: tb/tb_sort_sequencer.sv
// tb_sort_sequencer: directed table-driven bench for sort_sequencer with DWELL_CYCLES=4.
module tb_sort_sequencer;
    logic        CLK100MHZ = 1'b0;
    logic        CPU_RESETN = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_ready;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        busy, done;
    logic [2:0]  out_index;
    logic [15:0] outputVal;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] din;
        logic [15:0] asc;
        logic [15:0] dsc;
    } vec_t;
    vec_t        tbl [8];
    logic [15:0] exp_seq [8];

    sort_sequencer #(.DEPTH(8), .WIDTH(16), .DWELL_CYCLES(4)) dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .start      (start),
        .clear      (clear),
        .busy       (busy),
        .done       (done),
        .out_index  (out_index),
        .outputVal  (outputVal)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic step();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_one(input logic [15:0] v);
        load_valid = 1'b1;
        load_data  = v;
        step();
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic wait_sort(output int n);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
    endtask

    // Called on the first SHOW cycle; checks n values each held for hold cycles, then the wrap.
    task automatic check_show(input int n, input int hold);
        chk("done_in_show", done, 1);
        step();
        for (int k = 0; k < n; k++)
            for (int h = 0; h < hold; h++) begin
                chk("show_val", outputVal, exp_seq[k]);
                chk("show_idx", out_index, k);
                step();
            end
        chk("wrap_val", outputVal, exp_seq[0]);
        chk("wrap_idx", out_index, 0);
    endtask

    initial begin
        int n;
        tbl[0] = '{5, 1, 9}; tbl[1] = '{3, 2, 8}; tbl[2] = '{9, 3, 7}; tbl[3] = '{1, 5, 6};
        tbl[4] = '{7, 6, 5}; tbl[5] = '{2, 7, 3}; tbl[6] = '{8, 8, 2}; tbl[7] = '{6, 9, 1};

        repeat (2) step();
        chk("rst_val", outputVal, 0);
        chk("rst_idx", out_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", load_ready, 1);
        CPU_RESETN = 1'b1;
        step();

        // Unsorted table data
        for (int k = 0; k < 8; k++) begin
            load_one(tbl[k].din);
`ifdef SORT_DESCENDING_EN
            exp_seq[k] = tbl[k].dsc;
`else
            exp_seq[k] = tbl[k].asc;
`endif
        end
        pulse_start();
        chk("sort_busy", busy, 1);
        wait_sort(n);
        chk("sort_bounded", (n >= 7 && n <= 28), 1);
        check_show(8, 4);
        // Re-sort of already ordered data is a single clean pass
        pulse_start();
        chk("resort_busy", busy, 1);
        wait_sort(n);
        chk("resort_cycles", n, 7);
        check_show(1, 1);

        // Ascending input
        pulse_clear();
        chk("clr_done", done, 0);
        chk("clr_ready", load_ready, 1);
        for (int k = 0; k < 8; k++) load_one(16'(k + 1));
        pulse_start();
        wait_sort(n);
`ifdef SORT_DESCENDING_EN
        chk("asc_cycles", n, 28);
        for (int k = 0; k < 8; k++) exp_seq[k] = 16'(8 - k);
`else
        chk("asc_cycles", n, 7);
        for (int k = 0; k < 8; k++) exp_seq[k] = 16'(k + 1);
`endif
        check_show(8, 4);

        // Nine loads: ninth refused
        pulse_clear();
        for (int k = 0; k < 9; k++) begin
            chk("ovf_ready", load_ready, (k < 8) ? 1 : 0);
            load_one(16'(10 + k));
        end
        pulse_start();
        wait_sort(n);
`ifdef SORT_DESCENDING_EN
        for (int k = 0; k < 8; k++) exp_seq[k] = 16'(17 - k);
`else
        for (int k = 0; k < 8; k++) exp_seq[k] = 16'(10 + k);
`endif
        check_show(8, 4);

        // Empty start dropped; then load+start in one cycle goes straight to SHOW
        pulse_clear();
        pulse_start();
        chk("empty_busy", busy, 0);
        chk("empty_done", done, 0);
        chk("empty_ready", load_ready, 1);
        load_valid = 1'b1;
        load_data  = 16'd42;
        start      = 1'b1;
        step();
        load_valid = 1'b0;
        start      = 1'b0;
        chk("one_busy", busy, 0);
        exp_seq[0] = 16'd42;
        check_show(1, 20);

        // Clear mid-SORT; outputVal holds
        pulse_clear();
        for (int k = 0; k < 8; k++) load_one(16'(9 - k));
        pulse_start();
        step();
        step();
        chk("mid_busy", busy, 1);
        pulse_clear();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", load_ready, 1);
        chk("abort_hold", outputVal, 42);
        load_one(16'd4);
        load_one(16'd4);
        load_one(16'd0);
        pulse_start();
        wait_sort(n);
`ifdef SORT_DESCENDING_EN
        exp_seq[0] = 4; exp_seq[1] = 4; exp_seq[2] = 0;
`else
        exp_seq[0] = 0; exp_seq[1] = 4; exp_seq[2] = 4;
`endif
        check_show(3, 4);

        // Asynchronous reset mid-SHOW
        step();
        CPU_RESETN = 1'b0;
        #1;
        chk("arst_val", outputVal, 0);
        chk("arst_idx", out_index, 0);
        chk("arst_done", done, 0);
        chk("arst_ready", load_ready, 1);
        step();
        CPU_RESETN = 1'b1;
        step();
        chk("post_rst_done", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
